vector_index_encoder: RTL and testbench

Sequential encoder that converts a latched N-bit request vector into a stream of binary indices, one per set bit, lowest index first. It performs the inverse of the team's binary-to-one-hot decoders: a one-hot input yields exactly one index, and a multi-hot input is serialized. It sits between event/flag collectors and index-consuming logic (address generators, decoders) that need one binary index per transfer over a valid/ready link.

---
 rtl/encoder_pkg.sv | 15 +
 rtl/lsb_priority_encoder.sv | 29 ++
 rtl/vector_index_encoder.sv | 108 ++++++++++
 tb/tb_vector_index_encoder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the index encoder/decoder family:
// FSM state encoding and the index-width helper.
package encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Index width for an N-entry vector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit encoder with any/single flags.
module lsb_priority_encoder
  import encoder_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned W = idx_width(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_any,
  output logic         o_single
);

  logic [N-1:0] w_vec_minus1;

  assign w_vec_minus1 = i_vec - {{(N-1){1'b0}}, 1'b1};

  // Scan from the top so the lowest set bit wins the final assignment.
  always_comb begin
    o_idx = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      o_idx = i_vec[i] ? W'(i) : o_idx;
    end
  end

  assign o_any    = |i_vec;
  assign o_single = o_any && ((i_vec & w_vec_minus1) == {N{1'b0}});

endmodule

// File: rtl/vector_index_encoder.sv
// Serializes a latched request vector into ascending binary indices over a
// valid/ready link, accepting the next vector on the final handshake.
module vector_index_encoder
  import encoder_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         zero_drop
);

  state_e       r_state;
  state_e       w_state_nxt;
  logic [N-1:0] r_pending;
  logic [N-1:0] w_pending_nxt;
  logic [N-1:0] w_pending_cleared;
  logic         r_zero_drop;
  logic         w_zero_drop_nxt;
  logic [W-1:0] w_idx;
  logic         w_any;
  logic         w_single;
  logic         w_in_fire;
  logic         w_out_fire;
  logic         w_emit;

  lsb_priority_encoder #(.N(N)) u_lsb_enc (
    .i_vec    (r_pending),
    .o_idx    (w_idx),
    .o_any    (w_any),
    .o_single (w_single)
  );

  assign w_emit            = (r_state == EMIT);
  assign w_pending_cleared = r_pending & (r_pending - {{(N-1){1'b0}}, 1'b1});

  assign out_valid  = w_emit && w_any;
  assign out_idx    = w_emit ? w_idx : {W{1'b0}};
  assign out_last   = w_emit && w_single;
  assign in_ready   = w_emit ? (out_ready && w_single) : 1'b1;
  assign zero_drop  = r_zero_drop;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // Next-state, pending update and zero-drop detection.
  always_comb begin
    w_state_nxt     = r_state;
    w_pending_nxt   = r_pending;
    w_zero_drop_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_in_fire) begin
          if (in_vec != {N{1'b0}}) begin
            w_pending_nxt = in_vec;
            w_state_nxt   = EMIT;
          end else begin
            w_zero_drop_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      EMIT: begin
        if (w_out_fire && w_single) begin
          // Final index: reload from a concurrently accepted vector if any.
          if (w_in_fire && (in_vec != {N{1'b0}})) begin
            w_pending_nxt = in_vec;
            w_state_nxt   = EMIT;
          end else begin
            w_pending_nxt   = {N{1'b0}};
            w_state_nxt     = IDLE;
            w_zero_drop_nxt = w_in_fire;
          end
        end else if (w_out_fire) begin
          w_pending_nxt = w_pending_cleared;
        end else begin
          w_pending_nxt = r_pending;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_pending_nxt = {N{1'b0}};
      end
    endcase
  end

  // State, pending vector and zero-drop pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pending   <= {N{1'b0}};
      r_zero_drop <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_zero_drop <= w_zero_drop_nxt;
    end
  end

endmodule

// File: tb/tb_vector_index_encoder.sv
// Directed and scoreboarded checks for vector_index_encoder (N=8).
module tb_vector_index_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_vec = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_idx;
  logic       out_last;
  logic       zero_drop;

  int checks = 0;
  int errors = 0;

  vector_index_encoder #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .zero_drop (zero_drop)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_idx, out_last, zero_drop} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got rdy=%b vld=%b idx=%0d last=%b zd=%b want 1 0 0 0 0",
               in_ready, out_valid, out_idx, out_last, zero_drop);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [2:0] exp_idx [3] = '{3'd2, 3'd5, 3'd7};
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'b1010_0100; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0; in_vec = 8'hFF;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_idx !== exp_idx[k] || out_last !== (k == 2)) begin
        errors++;
        $display("FAIL basic_idx%0d got vld=%b idx=%0d last=%b want 1 %0d %0d",
                 k, out_valid, out_idx, out_last, exp_idx[k], (k == 2));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_done got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'b1010_0100; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_vec = 8'h00;
    #1;
    checks++;
    if (out_idx !== 3'd2) begin
      errors++;
      $display("FAIL stall_first got idx=%0d want 2", out_idx);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'd5 || out_last !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got vld=%b idx=%0d last=%b rdy=%b want 1 5 0 0",
                 k, out_valid, out_idx, out_last, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_idx !== 3'd5 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got idx=%0d last=%b want 5 0", out_idx, out_last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd7 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL stall_after got vld=%b idx=%0d last=%b want 1 7 1", out_valid, out_idx, out_last);
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'h00; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || zero_drop !== 1'b0) begin
      errors++;
      $display("FAIL zero_accept got rdy=%b zd=%b want 1 0", in_ready, zero_drop);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (zero_drop !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_pulse got zd=%b vld=%b rdy=%b want 1 0 1", zero_drop, out_valid, in_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (zero_drop !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_end got zd=%b vld=%b want 0 0", zero_drop, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'b1000_0000; out_ready = 1'b1;
    @(negedge clk);
    in_vec = 8'b0000_0011;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd7 || out_last !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got vld=%b idx=%0d last=%b rdy=%b want 1 7 1 1",
               out_valid, out_idx, out_last, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_vec = 8'h00;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got vld=%b idx=%0d last=%b rdy=%b want 1 0 0 0",
               out_valid, out_idx, out_last, in_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd1 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL b2b_third got vld=%b idx=%0d last=%b want 1 1 1", out_valid, out_idx, out_last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || zero_drop !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done got vld=%b zd=%b want 0 0", out_valid, zero_drop);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_idx !== 3'(k)) begin
        errors++;
        $display("FAIL rstmid_idx%0d got idx=%0d want %0d", k, out_idx, k);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async got vld=%b idx=%0d last=%b rdy=%b want 0 0 0 1",
               out_valid, out_idx, out_last, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_after%0d got vld=%b rdy=%b want 0 1", k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] cur;
    logic       exp_zd = 1'b0;
    logic       exp_zd_nxt;
    logic       exp_valid;
    logic       exp_rdy;
    logic [2:0] lo;
    int         r;
    for (int cyc = 0; cyc < 10020; cyc++) begin
      @(negedge clk);
      if (cyc < 10000) begin
        in_valid  = ($urandom_range(0, 2) != 0);
        r         = $urandom_range(0, 9);
        in_vec    = (r == 0) ? 8'h00 : (r < 4) ? (8'h01 << $urandom_range(0, 7)) : 8'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      exp_valid = (q.size() != 0);
      cur = exp_valid ? q[0] : 8'h00;
      lo = 3'd0;
      for (int i = 7; i >= 0; i--) begin
        if (cur[i]) lo = 3'(i);
      end
      exp_rdy = exp_valid ? (out_ready && ($countones(cur) == 1)) : 1'b1;
      checks++;
      if (out_valid !== exp_valid || in_ready !== exp_rdy || zero_drop !== exp_zd) begin
        errors++;
        $display("FAIL rand_ctrl cyc%0d got vld=%b rdy=%b zd=%b want %b %b %b",
                 cyc, out_valid, in_ready, zero_drop, exp_valid, exp_rdy, exp_zd);
      end
      if (exp_valid) begin
        checks++;
        if (out_idx !== lo || out_last !== ($countones(cur) == 1)) begin
          errors++;
          $display("FAIL rand_idx cyc%0d got idx=%0d last=%b want %0d %b",
                   cyc, out_idx, out_last, lo, ($countones(cur) == 1));
        end
      end
      exp_zd_nxt = 1'b0;
      if (exp_valid && out_ready) begin
        cur[lo] = 1'b0;
        if (cur == 8'h00) void'(q.pop_front());
        else q[0] = cur;
      end
      if (in_valid && exp_rdy) begin
        if (in_vec == 8'h00) exp_zd_nxt = 1'b1;
        else q.push_back(in_vec);
      end
      exp_zd = exp_zd_nxt;
    end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain got pending=%0d vld=%b want 0 0", q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
